mem_port: RTL and testbench
===========================

# mem_port

Parametrised memory access sequencer between the multicycle core datapath and a full-width word memory. It accepts one load or store per request (byte, half, word or dword), performs lane selection and sign/zero extension on loads, and merges sub-width stores. Stores are merged either by read-modify-write or by a single byte-enabled write. A memory handshake with wait states and a timeout replaces the fixed single-cycle memory of the previous core, so the core's `dtype`/`lbu` handling now lives in one block.

## Interface
- `N`, 64, data/address width; 32 or 64 only; `B = N/8` bytes per word, `L = log2(B)` lane bits.
- `TIMEOUT`, 16, max cycles `mem_req` may wait for `mem_ack`; 0 disables timeout.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: core request; accepted only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `unsigned_ld` in 1: zero-extend loads when 1, sign-extend when 0.
- `addr` in N: byte address.
- `wdata` in N: store data, right-justified.
- `rdata` out N: extended load result, valid while `done`=1.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misaligned, illegal size, or timeout.
- `busy` out 1: high in every state except IDLE.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: memory write.
- `mem_addr` out N: word-aligned address, `addr` with low L bits zeroed.
- `mem_wdata` out N: memory write data.
- `mem_be` out B: byte enables.
- `mem_rdata` in N: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: sampled at a rising edge while `mem_req`=1.
- `state` out 3: debug state code (IDLE 0, RD 1, WR 2, DONE 3).

## Operation
- Reset: all outputs 0, state IDLE, wait counter 0, internal registers 0.
- IDLE: on `req`=1, latch `we`, `size`, `unsigned_ld`, `addr` and `wdata`, then check legality.
  - Illegal means: `size`=11 with N=32; half with `addr[0]`≠0; word with `addr[1:0]`≠0; dword with `addr[2:0]`≠0.
  - If illegal, go to DONE with `err`=1 and make no memory access.
  - Otherwise, go to RD for a load or for a sub-width store in RMW mode; go to WR for all other stores.
- RD: `mem_req`=1, `mem_we`=0, `mem_be` all ones.
  - On ack for a load: lane = `addr[L-1:0]`, little-endian (byte o at bits [8o+7:8o]). Extract the sized field, extend it, register it into `rdata`, then go to DONE.
  - On ack for an RMW store: merge the low bytes of `wdata` into the read word at the lane, then go to WR.
- WR: `mem_req`=1, `mem_we`=1, `mem_wdata` = merged word (RMW) or lane-shifted `wdata`; on ack go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `rdata` holds its value until the next load completes.
- Timeout: the counter increments every cycle `mem_req`=1 without ack and clears on ack or on leaving RD/WR. When the counter reaches `TIMEOUT`, drop `mem_req` and go to DONE with `err`=1. A partial RMW write is never issued.
- `req` in any state other than IDLE is ignored and not queued.
- A dword store, or a word store with N=32, is always a single full-width WR.

## Timing
- Acceptance edge = cycle 0. `mem_req` is registered and first high in cycle 1.
- With a zero-wait memory (ack in the same cycle as `mem_req`):
  - load `done` in cycle 2;
  - direct store `done` in cycle 2;
  - RMW store `done` in cycle 3.
- Each wait cycle adds 1. Illegal access: `done`/`err` in cycle 1.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable throughout each `mem_req` phase.
- Asynchronous reset mid-operation forces IDLE immediately: `mem_req`, `done` and `busy` go to 0 without waiting for a clock edge. An outstanding ack is then ignored.
- `mem_ack` while `mem_req`=0 is ignored.

## Configuration
- `MEM_PORT_BYTEEN_EN` defined: sub-width stores go straight to WR with `mem_be` = lane mask; `mem_wdata` carries the data replicated into every lane of that width. No RD phase.
- `MEM_PORT_BYTEEN_EN` undefined: sub-width stores use RMW; `mem_be` is always all ones.

## Test plan
- Byte load, signed and unsigned: N=64, `addr`=0x1005, `mem_rdata`=0x0000_80FF_0000_0000, signed byte load.
  - Required: `rdata`=0xFFFF_FFFF_FFFF_FF80 in cycle 2.
  - Same access with `unsigned_ld`=1: `rdata`=0x80.
- RMW half store (macro off): `addr`=0x102, `wdata`=0xBEEF, read word 0x1111_2222_3333_4444.
  - Required: write of 0x1111_2222_BEEF_4444 to `mem_addr`=0x100, `done` in cycle 3.
- Byte-enable byte store (macro on): `addr`=0x107, `wdata`=0xAB.
  - Required: single write with `mem_be`=0x80, `mem_wdata`=0xABAB_ABAB_ABAB_ABAB, `done` in cycle 2, no read.
- Misaligned word load: `addr`=0x102.
  - Required: `done`=`err`=1 in cycle 1, `mem_req` never asserted.
  - Dword access with N=32: same response.
- Timeout: `TIMEOUT`=4, `mem_ack` held 0.
  - Required: `mem_req` high for 4 cycles then drops, `done`=`err`=1 next cycle, then IDLE.
- Wait states and reset: ack after 3 wait cycles gives load `done` in cycle 5.
  - Assert `reset` during WR: `mem_req`=0 immediately; a following `req` is accepted normally.

Source files
------------

// File: rtl/mem_port.sv
// mem_port: memory access sequencer between the core datapath and a full-width word memory.
//   Loads: lane select plus sign/zero extension. Stores: sub-width merge by read-modify-write,
//   or, when MEM_PORT_BYTEEN_EN is defined, by a single byte-enabled write with no read phase.
//   Memory handshake supports wait states, with a timeout after TIMEOUT unacked cycles (0 disables it).
//   Ports:
//     i_clk, i_reset         clock (rising edge), asynchronous active-high reset
//     i_req, i_we, i_size    core request, store flag, size (00 byte, 01 half, 10 word, 11 dword)
//     i_unsigned_ld          zero-extend (1) or sign-extend (0) loads
//     i_addr, i_wdata        byte address, right-justified store data
//     o_rdata                extended load result, valid with o_done and held until the next load
//     o_done, o_err, o_busy  completion pulse, error flag (valid with o_done), not-idle flag
//     o_mem_req, o_mem_we    memory request (held until ack), write strobe
//     o_mem_addr             word-aligned address
//     o_mem_wdata, o_mem_be  write data, byte enables
//     i_mem_rdata, i_mem_ack read data and acknowledge from memory
//     o_state                debug state code (IDLE 0, RD 1, WR 2, DONE 3)
module mem_port #(
  parameter int N = 64,
  parameter int TIMEOUT = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_req,
  input  logic           i_we,
  input  logic [1:0]     i_size,
  input  logic           i_unsigned_ld,
  input  logic [N-1:0]   i_addr,
  input  logic [N-1:0]   i_wdata,
  output logic [N-1:0]   o_rdata,
  output logic           o_done,
  output logic           o_err,
  output logic           o_busy,
  output logic           o_mem_req,
  output logic           o_mem_we,
  output logic [N-1:0]   o_mem_addr,
  output logic [N-1:0]   o_mem_wdata,
  output logic [N/8-1:0] o_mem_be,
  input  logic [N-1:0]   i_mem_rdata,
  input  logic           i_mem_ack,
  output logic [2:0]     o_state
);
  localparam int B = N / 8;
  localparam int L = $clog2(B);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
`ifdef MEM_PORT_BYTEEN_EN
  localparam bit BYTEEN = 1'b1;
`else
  localparam bit BYTEEN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t        r_state, w_next;
  logic          r_we, r_uns, r_err, w_err;
  logic [1:0]    r_size;
  logic [N-1:0]  r_addr, r_wdata, r_rdata, r_mwdata;
  logic [CW-1:0] r_cnt;

  logic          w_req_phase, w_to, w_illegal, w_full_in, w_sign;
  logic [L-1:0]  w_lane;
  logic [N-1:0]  w_sh, w_fmask, w_ext, w_bits, w_merge, w_rep;
  logic [B-1:0]  w_szbe, w_lbe;

  assign w_lane      = r_addr[L-1:0];
  assign w_req_phase = r_state == RD || r_state == WR;
  // Counter holds the number of unacked cycles already spent; the last allowed one ends the phase.
  assign w_to        = (TIMEOUT != 0) && w_req_phase && !i_mem_ack && r_cnt == CW'(TIMEOUT - 1);

  // Legality and store classification are judged on the request as presented in IDLE.
  assign w_illegal = (i_size == 2'd3 && N == 32) || (i_size == 2'd1 && i_addr[0]) ||
                     (i_size == 2'd2 && i_addr[1:0] != 2'b00) || (i_size == 2'd3 && i_addr[2:0] != 3'b000);
  assign w_full_in = i_size == 2'd3 || (N == 32 && i_size == 2'd2);
  assign w_rep     = i_size == 2'd0 ? {B{i_wdata[7:0]}} :
                     i_size == 2'd1 ? {(B/2){i_wdata[15:0]}} :
                     i_size == 2'd2 ? {(B/4){i_wdata[31:0]}} : i_wdata;

  // Load path: bring the addressed lane down to bit 0, keep the sized field, fill above it.
  assign w_sh    = i_mem_rdata >> {w_lane, 3'b000};
  assign w_fmask = r_size == 2'd0 ? N'(8'hFF) :
                   r_size == 2'd1 ? N'(16'hFFFF) :
                   r_size == 2'd2 ? N'(32'hFFFF_FFFF) : {N{1'b1}};
  assign w_sign  = !r_uns && (r_size == 2'd0 ? w_sh[7] :
                              r_size == 2'd1 ? w_sh[15] :
                              r_size == 2'd2 ? w_sh[31] : w_sh[N-1]);
  assign w_ext   = (w_sh & w_fmask) | ({N{w_sign}} & ~w_fmask);

  // Store path: byte lane mask for the latched access, expanded to a bit mask for merging.
  assign w_szbe = r_size == 2'd0 ? B'(1) :
                  r_size == 2'd1 ? B'(3) :
                  r_size == 2'd2 ? B'(15) : {B{1'b1}};
  assign w_lbe  = w_szbe << w_lane;
  for (genvar i = 0; i < B; i++) begin : g_bits
    assign w_bits[8*i +: 8] = {8{w_lbe[i]}};
  end
  assign w_merge = (i_mem_rdata & ~w_bits) | ((r_wdata << {w_lane, 3'b000}) & w_bits);

  always_comb begin
    w_next      = r_state;
    w_err       = r_err;
    o_busy      = r_state != IDLE;
    o_done      = r_state == DONE;
    o_err       = r_state == DONE && r_err;
    o_mem_req   = w_req_phase;
    o_mem_we    = r_state == WR;
    o_mem_be    = r_state == RD ? {B{1'b1}} : r_state == WR ? (BYTEEN ? w_lbe : {B{1'b1}}) : '0;
    o_mem_addr  = {r_addr[N-1:L], {L{1'b0}}};
    o_mem_wdata = r_mwdata;
    o_rdata     = r_rdata;
    o_state     = r_state;
    case (r_state)
      IDLE: if (i_req) begin
        w_err  = w_illegal;
        w_next = w_illegal ? DONE : (!i_we || (!w_full_in && !BYTEEN)) ? RD : WR;
      end
      RD: if (w_to) begin
        w_err  = 1'b1;
        w_next = DONE;
      end else if (i_mem_ack) w_next = r_we ? WR : DONE;
      WR: if (w_to) begin
        w_err  = 1'b1;
        w_next = DONE;
      end else if (i_mem_ack) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_mwdata <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_cnt   <= (w_req_phase && !i_mem_ack && !w_to) ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && i_req) begin
        r_we     <= i_we;
        r_size   <= i_size;
        r_uns    <= i_unsigned_ld;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
        // Full-width stores sit at lane 0, so the unshifted data is already lane-aligned.
        r_mwdata <= BYTEEN ? w_rep : i_wdata;
      end
      // A timeout only fires without ack, so an acked read always completes its merge or load.
      if (r_state == RD && i_mem_ack) begin
        if (r_we) r_mwdata <= w_merge;
        else r_rdata <= w_ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: directed and randomized checks of mem_port against a byte-level memory model
module tb_mem_port;
`ifdef MEM_PORT_BYTEEN_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req = 0, we = 0, uns = 0, mack = 0;
  logic [1:0]  size = 0;
  logic [63:0] addr = 0, wdata = 0, mrdata = 0;
  logic [63:0] rdata, maddr, mwdata;
  logic [7:0]  mbe;
  logic [2:0]  state;
  logic        done, err, busy, mreq, mwe;

  logic        req32 = 0;
  logic [1:0]  size32 = 0;
  logic [31:0] addr32 = 0;
  logic [31:0] rdata32, maddr32, mwdata32;
  logic [3:0]  mbe32;
  logic [2:0]  state32;
  logic        done32, err32, busy32, mreq32, mwe32;

  mem_port #(.N(64), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_size(size), .i_unsigned_ld(uns),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_done(done), .o_err(err), .o_busy(busy),
    .o_mem_req(mreq), .o_mem_we(mwe), .o_mem_addr(maddr), .o_mem_wdata(mwdata), .o_mem_be(mbe),
    .i_mem_rdata(mrdata), .i_mem_ack(mack), .o_state(state)
  );

  mem_port #(.N(32), .TIMEOUT(4)) dut32 (
    .i_clk(clk), .i_reset(rst), .i_req(req32), .i_we(1'b0), .i_size(size32), .i_unsigned_ld(1'b0),
    .i_addr(addr32), .i_wdata(32'h0), .o_rdata(rdata32), .o_done(done32), .o_err(err32), .o_busy(busy32),
    .o_mem_req(mreq32), .o_mem_we(mwe32), .o_mem_addr(maddr32), .o_mem_wdata(mwdata32), .o_mem_be(mbe32),
    .i_mem_rdata(32'h0), .i_mem_ack(1'b0), .o_state(state32)
  );

  logic [63:0] dmem [logic [63:0]];
  logic [7:0]  rmem [logic [63:0]];
  int          wait_n = 0, n_rd = 0, n_wr = 0, unstable = 0;
  int          checks = 0, fails = 0;
  logic [63:0] last_waddr = 0, last_wdata = 0;
  logic [7:0]  last_be = 0;

  function automatic logic [63:0] rd_word(input logic [63:0] a);
    return dmem.exists(a) ? dmem[a] : 64'd0;
  endfunction

  function automatic logic [7:0] rbyte(input logic [63:0] a);
    return rmem.exists(a) ? rmem[a] : 8'd0;
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0] v = 0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = rbyte(a + 64'(k));
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] s, input logic u);
    int nb = 1 << s;
    logic [63:0] v = 0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = rbyte(a + 64'(k));
    if (!u && nb < 8 && v[8*nb-1]) v = v - (64'd1 << (8*nb));
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    for (int k = 0; k < (1 << s); k++) rmem[a + 64'(k)] = d[8*k +: 8];
  endtask

  task automatic preload(input logic [63:0] wa, input logic [63:0] v);
    dmem[wa] = v;
    for (int k = 0; k < 8; k++) rmem[wa + 64'(k)] = v[8*k +: 8];
  endtask

  function automatic int exp_cyc(input logic w, input logic [1:0] s, input logic legal, input int wt);
    if (!legal) return 1;
    if (w && s != 2'd3 && !BE) return 3 + 2 * wt;
    return 2 + wt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after wait_n wait cycles, applies byte-enabled writes,
  // and notes any change of the request attributes inside one request phase.
  initial begin
    int wcnt = 0;
    logic ph_on = 0;
    logic [136:0] ph = 0;
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (mack || !mreq) ph_on = 0;
      mack = 0;
      if (!mreq) wcnt = 0;
      else begin
        if (ph_on && ph !== {maddr, mwdata, mbe, mwe}) unstable++;
        ph_on = 1;
        ph = {maddr, mwdata, mbe, mwe};
        if (wcnt < wait_n) begin
          wcnt++;
          mrdata = {$urandom, $urandom};
        end else begin
          wcnt = 0;
          mack = 1;
          if (mwe) begin
            w = rd_word(maddr);
            for (int b = 0; b < 8; b++) if (mbe[b]) w[8*b +: 8] = mwdata[8*b +: 8];
            dmem[maddr] = w;
            n_wr++;
            last_waddr = maddr;
            last_wdata = mwdata;
            last_be = mbe;
            mrdata = {$urandom, $urandom};
          end else begin
            mrdata = rd_word(maddr);
            n_rd++;
          end
        end
      end
    end
  end

  // One access: present the request for one edge, scramble inputs afterwards, pulse req while busy
  // (must be ignored), and report the cycle of done counted from the acceptance edge.
  task automatic access(input logic w, input logic [1:0] s, input logic u, input logic [63:0] a,
                        input logic [63:0] d, input int wt,
                        output int cyc, output logic [63:0] rd, output logic e, output int reqc);
    cyc = 0; rd = 0; e = 0; reqc = 0;
    @(negedge clk);
    wait_n = wt; req = 1; we = w; size = s; uns = u; addr = a; wdata = d;
    for (int c = 1; c <= 60 && cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end
      reqc += int'(mreq);
      if (done) begin
        cyc = c; rd = rdata; e = err; req = 0;
      end else req = 1'($urandom);
    end
    req = 0;
  endtask

  initial begin
    int cyc, reqc, rd0, w0, wt, nb, ec;
    logic [63:0] rd, a, d;
    logic e, w, u, legal;
    logic [1:0] s;
    #1;
    chk("rst_ctl", {done, err, busy, mreq, mwe, state}, 0);
    chk("rst_data", rdata | maddr | mwdata, 0);
    chk("rst_be", mbe, 0);
    chk("rst32", {done32, err32, busy32, mreq32, state32}, 0);
    @(negedge clk);
    rst = 0;

    preload(64'h1000, 64'h0000_80FF_0000_0000);
    access(0, 2'd0, 0, 64'h1005, {$urandom, $urandom}, 0, cyc, rd, e, reqc);
    chk("lb_cyc", cyc, 2);
    chk("lb_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_err", e, 0);
    access(0, 2'd0, 1, 64'h1005, {$urandom, $urandom}, 0, cyc, rd, e, reqc);
    chk("lbu_data", rd, 64'h80);

    preload(64'h100, 64'h1111_2222_3333_4444);
    rd0 = n_rd;
    d = {$urandom, 16'h0, 16'hBEEF};
    access(1, 2'd1, 0, 64'h102, d, 0, cyc, rd, e, reqc);
    ref_store(64'h102, 2'd1, d);
    chk("sh_word", rd_word(64'h100), 64'h1111_2222_BEEF_4444);
    chk("sh_addr", last_waddr, 64'h100);
    chk("sh_cyc", cyc, BE ? 2 : 3);
    chk("sh_reads", n_rd - rd0, BE ? 0 : 1);
    chk("sh_err", e, 0);

    rd0 = n_rd;
    access(1, 2'd0, 0, 64'h107, 64'hAB, 0, cyc, rd, e, reqc);
    ref_store(64'h107, 2'd0, 64'hAB);
    chk("sb_word", rd_word(64'h100), 64'hAB11_2222_BEEF_4444);
    chk("sb_be", last_be, BE ? 8'h80 : 8'hFF);
    chk("sb_wdata", last_wdata, BE ? 64'hABAB_ABAB_ABAB_ABAB : 64'hAB11_2222_BEEF_4444);
    chk("sb_cyc", cyc, BE ? 2 : 3);
    chk("sb_reads", n_rd - rd0, BE ? 0 : 1);

    access(0, 2'd2, 0, 64'h102, 0, 0, cyc, rd, e, reqc);
    chk("mis_cyc", cyc, 1);
    chk("mis_err", e, 1);
    chk("mis_noreq", reqc, 0);

    @(negedge clk);
    req32 = 1; size32 = 2'd3; addr32 = 32'h100;
    @(negedge clk);
    req32 = 0;
    chk("n32_dword", {done32, err32, mreq32}, 3'b110);
    @(negedge clk);
    req32 = 1; size32 = 2'd2; addr32 = 32'h102;
    @(negedge clk);
    req32 = 0;
    chk("n32_mis", {done32, err32, mreq32}, 3'b110);
    @(negedge clk);
    req32 = 1; addr32 = 32'h106;
    addr32 = 32'h104;
    @(negedge clk);
    req32 = 0;
    chk("n32_req", {mreq32, maddr32, mbe32, done32}, {1'b1, 32'h104, 4'hF, 1'b0});
    repeat (4) @(negedge clk);
    chk("n32_to", {done32, err32, mreq32}, 3'b110);

    rd0 = n_rd;
    access(0, 2'd3, 0, 64'h1000, 0, 100, cyc, rd, e, reqc);
    chk("to_cyc", cyc, 5);
    chk("to_err", e, 1);
    chk("to_reqc", reqc, 4);
    chk("to_reads", n_rd - rd0, 0);
    @(negedge clk);
    chk("to_idle", {state, busy}, 0);

    access(0, 2'd2, 1, 64'h1004, 0, 3, cyc, rd, e, reqc);
    chk("ws_cyc", cyc, 5);
    chk("ws_data", rd, ref_load(64'h1004, 2'd2, 1));

    wait_n = 100;
    w0 = n_wr;
    @(negedge clk);
    req = 1; we = 1; size = 2'd3; addr = 64'h1100; wdata = {$urandom, $urandom};
    @(negedge clk);
    req = 0;
    chk("wr_phase", {mreq, mwe}, 2'b11);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_async", {mreq, done, busy, state}, 0);
    @(negedge clk);
    rst = 0;
    chk("rst_nowr", n_wr - w0, 0);
    access(0, 2'd3, 0, 64'h1000, 0, 0, cyc, rd, e, reqc);
    chk("post_cyc", cyc, 2);
    chk("post_data", rd, ref_load(64'h1000, 2'd3, 0));

    for (int k = 0; k < 8; k++) preload(64'h1000 + 64'(8 * k), {$urandom, $urandom});
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom);
      s = 2'($urandom);
      u = 1'($urandom);
      nb = 1 << s;
      a = 64'h1000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      legal = (a % 64'(nb)) == 0;
      d = {$urandom, $urandom};
      wt = $urandom_range(0, 2);
      ec = exp_cyc(w, s, legal, wt);
      rd0 = n_rd;
      access(w, s, u, a, d, wt, cyc, rd, e, reqc);
      chk("rnd_cyc", 64'(cyc), 64'(ec));
      chk("rnd_err", e, !legal);
      chk("rnd_reqc", 64'(reqc), legal ? 64'(ec - 1) : 0);
      chk("rnd_reads", 64'(n_rd - rd0), 64'(legal && (!w || (s != 2'd3 && !BE))));
      if (legal && !w) chk("rnd_load", rd, ref_load(a, s, u));
      if (legal && w) begin
        ref_store(a, s, d);
        chk("rnd_store", rd_word(a & ~64'h7), ref_word(a & ~64'h7));
      end
    end
    chk("stable", unstable, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
